// File: rtl/fc_argmax.sv
// Final LeNet stage: reads the FC-2 score word from fm_bram_1 port B, scans the
// class lanes one per cycle and reports the highest-scoring class (lowest index wins ties).
module fc_argmax #(
   parameter int N_CLASS     = 10,
   parameter int W_SCORE     = 16,
   parameter int RESULT_ADDR = 0,
   parameter int WORD_W      = 896
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                argmax_en,
   output logic                fm_bram_1_enb,
   output logic [6:0]          fm_bram_1_addrb,
   input  logic [WORD_W-1:0]   fm_bram_1_doutb,
   input  logic                fm_bram_1_rdb_vld,
   output logic [3:0]          class_idx,
   output logic [W_SCORE-1:0]  class_score,
   output logic                result_vld,
   output logic                argmax_finish
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, SCAN, DONE} state_t;

   state_t                     state;
   logic                       en_d;
   logic                       en_p;
   logic [3:0]                 lane;
   logic [W_SCORE-1:0]         lanes_q [N_CLASS];
   logic signed [W_SCORE-1:0]  best;
   logic [3:0]                 best_idx;

   logic signed [W_SCORE-1:0]  lane_val;
   logic                       better;
   logic signed [W_SCORE-1:0]  nxt_best;
   logic [3:0]                 nxt_idx;
   logic                       unused_upper;

   // Only the low N_CLASS lanes of the BRAM word carry scores.
   assign unused_upper = ^fm_bram_1_doutb[WORD_W-1:N_CLASS*W_SCORE];

   always_comb begin
      lane_val = $signed(lanes_q[lane]);
      better   = lane_val > best;
      nxt_best = better ? lane_val : best;
      nxt_idx  = better ? lane : best_idx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         en_d            <= 1'b0;
         en_p            <= 1'b0;
         lane            <= '0;
         best            <= '0;
         best_idx        <= '0;
         fm_bram_1_enb   <= 1'b0;
         fm_bram_1_addrb <= '0;
         class_idx       <= '0;
         class_score     <= '0;
         result_vld      <= 1'b0;
         argmax_finish   <= 1'b0;
         for (int i = 0; i < N_CLASS; i++) lanes_q[i] <= '0;
      end else begin
         en_d          <= argmax_en;
         en_p          <= argmax_en & ~en_d;
         fm_bram_1_enb <= 1'b0;
         result_vld    <= 1'b0;
         // Dropping the enable aborts at once; a fresh rising edge restarts from READ.
         if (!argmax_en) begin
            state <= IDLE;
         end else if (en_p) begin
            state           <= READ;
            fm_bram_1_enb   <= 1'b1;
            fm_bram_1_addrb <= 7'(RESULT_ADDR);
            argmax_finish   <= 1'b0;
         end else begin
            case (state)
               READ: state <= WAIT;
               WAIT: begin
                  if (fm_bram_1_rdb_vld) begin
                     for (int i = 0; i < N_CLASS; i++)
                        lanes_q[i] <= fm_bram_1_doutb[i*W_SCORE +: W_SCORE];
                     best     <= $signed(fm_bram_1_doutb[W_SCORE-1:0]);
                     best_idx <= '0;
                     lane     <= 4'd1;
                     state    <= SCAN;
                  end
               end
               SCAN: begin
                  best     <= nxt_best;
                  best_idx <= nxt_idx;
                  if (lane == 4'(N_CLASS-1)) begin
                     class_idx     <= nxt_idx;
                     class_score   <= nxt_best;
                     result_vld    <= 1'b1;
                     argmax_finish <= 1'b1;
                     state         <= DONE;
                  end else begin
                     lane <= lane + 4'd1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: a BRAM port-B responder plus a max-then-first-index reference
// model, compared against the DUT outputs every cycle.
module tb_fc_argmax;

   localparam int N_CLASS = 10;
   localparam int W_SCORE = 16;
   localparam int WORD_W  = 896;

   logic                clk = 1'b0;
   logic                rst;
   logic                argmax_en;
   logic                fm_bram_1_enb;
   logic [6:0]          fm_bram_1_addrb;
   logic [WORD_W-1:0]   fm_bram_1_doutb;
   logic                fm_bram_1_rdb_vld;
   logic [3:0]          class_idx;
   logic [W_SCORE-1:0]  class_score;
   logic                result_vld;
   logic                argmax_finish;

   int checks = 0, errors = 0, cyc = 0;
   int enb_at = -1, vld_at = -1, fin_clear_at = -1;
   int cur_idx = 0, cur_score = 0, cur_fin = 0, pend_idx = 0, pend_score = 0;
   bit check_en = 1'b0;
   logic [W_SCORE-1:0] sc [N_CLASS];
   logic [WORD_W-1:0]  bram_word = '0;

   fc_argmax dut (
      .clk               (clk),
      .rst               (rst),
      .argmax_en         (argmax_en),
      .fm_bram_1_enb     (fm_bram_1_enb),
      .fm_bram_1_addrb   (fm_bram_1_addrb),
      .fm_bram_1_doutb   (fm_bram_1_doutb),
      .fm_bram_1_rdb_vld (fm_bram_1_rdb_vld),
      .class_idx         (class_idx),
      .class_score       (class_score),
      .result_vld        (result_vld),
      .argmax_finish     (argmax_finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: the class score is the maximum lane value; the class is the first lane holding it.
   task automatic modelArgmax(output int idx, output int score);
      int mx;
      mx  = -32768;
      idx = -1;
      for (int i = 0; i < N_CLASS; i++)
         if (int'($signed(sc[i])) > mx) mx = int'($signed(sc[i]));
      for (int i = 0; i < N_CLASS; i++)
         if (idx < 0 && int'($signed(sc[i])) == mx) idx = i;
      score = mx & 32'h0000FFFF;
   endtask

   // BRAM port B: data valid two cycles after the read-enable pulse.
   initial begin
      fm_bram_1_rdb_vld = 1'b0;
      fm_bram_1_doutb   = '0;
      forever begin
         @(negedge clk);
         if (fm_bram_1_enb === 1'b1) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            fm_bram_1_doutb   = bram_word;
            fm_bram_1_rdb_vld = 1'b1;
            @(posedge clk);
            #1;
            fm_bram_1_rdb_vld = 1'b0;
            fm_bram_1_doutb   = '0;
         end
      end
   end

   // Per-cycle comparison of every output against the model's expected timeline.
   always @(negedge clk) begin
      if (check_en) begin
         if (cyc == fin_clear_at) cur_fin = 0;
         if (cyc == vld_at) begin
            cur_idx   = pend_idx;
            cur_score = pend_score;
            cur_fin   = 1;
         end
         checkOutput("result_vld", 32'(result_vld), 32'(cyc == vld_at));
         checkOutput("enb", 32'(fm_bram_1_enb), 32'(cyc == enb_at));
         if (cyc == enb_at) checkOutput("addrb", 32'(fm_bram_1_addrb), 32'd0);
         checkOutput("class_idx", 32'(class_idx), 32'(cur_idx));
         checkOutput("class_score", 32'(class_score), 32'(cur_score));
         checkOutput("argmax_finish", 32'(argmax_finish), 32'(cur_fin));
      end
   end

   task automatic loadWord(input bit upper_ones);
      bram_word = upper_ones ? '1 : '0;
      for (int i = 0; i < N_CLASS; i++) bram_word[i*W_SCORE +: W_SCORE] = sc[i];
   endtask

   task automatic startPass();
      int e;
      modelArgmax(pend_idx, pend_score);
      e            = cyc + 1;
      enb_at       = e + 1;
      fin_clear_at = e + 1;
      vld_at       = e + 13;
      argmax_en    = 1'b1;
   endtask

   // Runs one pass from a negedge; abort_at > 0 drops the enable that many cycles after en_p.
   task automatic applyStimulus(input string name, input bit upper_ones, input int abort_at,
                                input int lit_idx, input int lit_score, input int hold_after);
      int m_idx, m_score;
      modelArgmax(m_idx, m_score);
      checkOutput({name, "_model_idx"}, 32'(m_idx), 32'(lit_idx));
      checkOutput({name, "_model_score"}, 32'(m_score), 32'(lit_score));
      loadWord(upper_ones);
      startPass();
      if (abort_at > 0) begin
         repeat (abort_at + 1) @(negedge clk);
         argmax_en = 1'b0;
         vld_at    = -1;
         repeat (4) @(negedge clk);
      end else begin
         repeat (15) @(negedge clk);
         checkOutput({name, "_idx"}, 32'(class_idx), 32'(lit_idx));
         checkOutput({name, "_score"}, 32'(class_score), 32'(lit_score));
         checkOutput({name, "_finish"}, 32'(argmax_finish), 32'd1);
         repeat (hold_after) @(negedge clk);
         argmax_en = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst       = 1'b0;
      argmax_en = 1'b0;
      #12;
      checkOutput("rst_enb", 32'(fm_bram_1_enb), 32'd0);
      checkOutput("rst_addrb", 32'(fm_bram_1_addrb), 32'd0);
      checkOutput("rst_idx", 32'(class_idx), 32'd0);
      checkOutput("rst_score", 32'(class_score), 32'd0);
      checkOutput("rst_vld", 32'(result_vld), 32'd0);
      checkOutput("rst_finish", 32'(argmax_finish), 32'd0);
      @(negedge clk);
      rst      = 1'b1;
      check_en = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'(i * 100);
      applyStimulus("ramp", 1'b0, 0, 9, 900, 8);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'h0005;
      sc[3] = 16'h7FFF;
      sc[7] = 16'h7FFF;
      applyStimulus("tie", 1'b0, 0, 3, 16'h7FFF, 0);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'(-(i + 2));
      sc[0] = 16'h8000;
      sc[4] = 16'hFFFF;
      applyStimulus("neg", 1'b0, 0, 4, 16'hFFFF, 0);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'h0000;
      applyStimulus("upper", 1'b1, 0, 0, 0, 0);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'(i * 7);
      sc[5] = 16'd1234;
      applyStimulus("abort", 1'b0, 7, 5, 1234, 0);
      applyStimulus("rerun", 1'b0, 0, 5, 1234, 0);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'h0100;
      loadWord(1'b0);
      startPass();
      repeat (3) @(posedge clk);
      #3;
      rst          = 1'b0;
      argmax_en    = 1'b0;
      enb_at       = -1;
      vld_at       = -1;
      fin_clear_at = -1;
      cur_idx      = 0;
      cur_score    = 0;
      cur_fin      = 0;
      #1;
      checkOutput("midrst_idx", 32'(class_idx), 32'd0);
      checkOutput("midrst_score", 32'(class_score), 32'd0);
      checkOutput("midrst_enb", 32'(fm_bram_1_enb), 32'd0);
      checkOutput("midrst_vld", 32'(result_vld), 32'd0);
      checkOutput("midrst_finish", 32'(argmax_finish), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);

      for (int i = 0; i < N_CLASS; i++) sc[i] = 16'h8000;
      applyStimulus("allmin", 1'b0, 0, 0, 16'h8000, 0);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
